// File: rtl/store_aligner.sv
// Store data aligner: lane-shifts rs2 data and byte enables into word-aligned memory writes.
// Optional MISALIGNED_SPLIT_EN issues boundary-crossing stores as two writes; otherwise they are rejected.
module store_aligner (
    input  logic        clk,
    input  logic        rst,
    input  logic        store_req,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    output logic        store_ready,
    output logic        store_done,
    output logic        store_misaligned,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_write,
    input  logic        mem_resp
);

`ifdef MISALIGNED_SPLIT_EN
    localparam logic split_en = 1'b1;
`else
    localparam logic split_en = 1'b0;
`endif

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [29:0] word_addr_reg;
    logic [31:0] lo_data_reg, hi_data_reg;
    logic [3:0]  lo_be_reg, hi_be_reg;
    logic        spill_reg;
    logic        mis_reg;

    logic        valid_c;
    logic [3:0]  base_mask_c;
    logic [31:0] sized_data_c;
    logic [63:0] shifted_c;
    logic [7:0]  mask8_c;
    logic        spill_c;
    logic        accept_c;

    always_comb begin
        valid_c      = 1'b1;
        base_mask_c  = 4'b0000;
        sized_data_c = 32'd0;
        case (funct3)
            F3_SB: begin
                base_mask_c  = 4'b0001;
                sized_data_c = {24'd0, store_data[7:0]};
            end
            F3_SH: begin
                base_mask_c  = 4'b0011;
                sized_data_c = {16'd0, store_data[15:0]};
            end
            F3_SW: begin
                base_mask_c  = 4'b1111;
                sized_data_c = store_data;
            end
            default: valid_c = 1'b0;
        endcase
    end

    // A 64-bit window spanning two words absorbs the shift; the high half is the spill.
    assign shifted_c = {32'd0, sized_data_c} << {store_addr[1:0], 3'b000};
    assign mask8_c   = {4'b0000, base_mask_c} << store_addr[1:0];
    assign spill_c   = |mask8_c[7:4];
    assign accept_c  = (state_reg == IDLE) && store_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            word_addr_reg <= 30'd0;
            lo_data_reg   <= 32'd0;
            hi_data_reg   <= 32'd0;
            lo_be_reg     <= 4'd0;
            hi_be_reg     <= 4'd0;
            spill_reg     <= 1'b0;
            mis_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept_c) begin
                word_addr_reg <= store_addr[31:2];
                lo_data_reg   <= shifted_c[31:0];
                hi_data_reg   <= shifted_c[63:32];
                lo_be_reg     <= mask8_c[3:0];
                hi_be_reg     <= mask8_c[7:4];
                spill_reg     <= spill_c;
                mis_reg       <= valid_c && spill_c && !split_en;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (store_req) begin
                    if (!valid_c || (spill_c && !split_en))
                        state_next = DONE;
                    else
                        state_next = WR_LO;
                end
            end
            WR_LO: begin
                if (mem_resp)
                    state_next = (spill_reg && split_en) ? WR_HI : DONE;
            end
            WR_HI: begin
                if (mem_resp)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic [3:0]  sel_be;

    always_comb begin
        mem_write = 1'b0;
        sel_addr  = 32'd0;
        sel_data  = 32'd0;
        sel_be    = 4'd0;
        case (state_reg)
            WR_LO: begin
                mem_write = 1'b1;
                sel_addr  = {word_addr_reg, 2'b00};
                sel_data  = lo_data_reg;
                sel_be    = lo_be_reg;
            end
            WR_HI: begin
                mem_write = 1'b1;
                sel_addr  = {word_addr_reg + 30'd1, 2'b00};
                sel_data  = hi_data_reg;
                sel_be    = hi_be_reg;
            end
            default: ;
        endcase
    end

    // Disabled lanes are forced to zero regardless of what the data register holds.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_wdata[8*gi +: 8] = sel_be[gi] ? sel_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign mem_address      = sel_addr;
    assign mem_byte_enable  = sel_be;
    assign store_ready      = (state_reg == IDLE);
    assign store_done       = (state_reg == DONE);
    assign store_misaligned = (state_reg == DONE) && mis_reg;

endmodule
